// File: rtl/fsm_encode_ctrl_pkg.sv
// Shared definitions for the fsm_encode_ctrl sequencing skeleton: state
// enumeration, per-encoding state codes, Moore output tuples and the
// code <-> state helpers used by both the controller and its output decoder.
package fsm_encode_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_S1    = 3'd1,
    ST_S2    = 3'd2,
    ST_S3    = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  localparam int NUM_STATES = 5;

  // Encoding selectors for the ENCODING parameter
  localparam int ENC_BINARY = 0;
  localparam int ENC_ONEHOT = 1;
  localparam int ENC_GRAY   = 2;

  // Moore output tuple; n_o1 is active-low, o[0]=o2, o[1]=o3, o[2]=o4
  typedef struct packed {
    logic       n_o1;
    logic [2:0] o;
    logic       err;
  } out_t;

  localparam out_t OUT_IDLE  = '{n_o1: 1'b1, o: 3'b000, err: 1'b0};
  localparam out_t OUT_S1    = '{n_o1: 1'b0, o: 3'b001, err: 1'b0};
  localparam out_t OUT_S2    = '{n_o1: 1'b1, o: 3'b011, err: 1'b0};
  localparam out_t OUT_S3    = '{n_o1: 1'b1, o: 3'b100, err: 1'b0};
  localparam out_t OUT_ERROR = '{n_o1: 1'b1, o: 3'b000, err: 1'b1};

  // Result of decoding a raw state code
  typedef struct packed {
    logic   legal;
    state_e st;
  } dec_t;

  // Width of the state register for a given encoding
  function automatic int state_w(input int enc);
    return (enc == ENC_ONEHOT) ? 5 : 3;
  endfunction

  // State code for a state, zero-extended to 5 bits
  function automatic logic [4:0] encode_state(input int enc, input state_e s);
    logic [4:0] c;
    c = 5'd0;
    case (enc)
      ENC_ONEHOT: c = 5'b00001 << s;
      ENC_GRAY: begin
        case (s)
          ST_IDLE:  c = 5'b00000;
          ST_S1:    c = 5'b00001;
          ST_S2:    c = 5'b00011;
          ST_S3:    c = 5'b00010;
          ST_ERROR: c = 5'b00110;
          default:  c = 5'b00000;
        endcase
      end
      default: c = {2'b00, s};
    endcase
    return c;
  endfunction

  // Map a raw code back to a state; anything not in the table is illegal
  function automatic dec_t decode_state(input int enc, input logic [4:0] code);
    dec_t d;
    d.legal = 1'b0;
    d.st    = ST_ERROR;
    for (int k = 0; k < NUM_STATES; k++) begin
      if (code == encode_state(enc, state_e'(3'(k)))) begin
        d.legal = 1'b1;
        d.st    = state_e'(3'(k));
      end
    end
    return d;
  endfunction

  // Moore outputs for a legal state
  function automatic out_t state_outputs(input state_e s);
    out_t v;
    case (s)
      ST_IDLE: v = OUT_IDLE;
      ST_S1:   v = OUT_S1;
      ST_S2:   v = OUT_S2;
      ST_S3:   v = OUT_S3;
      default: v = OUT_ERROR;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fsm_out_decode.sv
// Output decoder: maps a raw state code to the Moore outputs. Codes that do
// not belong to the selected encoding produce the ERROR tuple.
module fsm_out_decode
  import fsm_encode_ctrl_pkg::*;
#(
  parameter int ENCODING = 0,
  parameter int SW       = 3
) (
  input  logic [SW-1:0] code,
  output logic          n_o1,
  output logic [2:0]    o,
  output logic          err
);

  logic [NUM_STATES-1:0] hit;
  out_t                  v;

  // One comparator per state against its code in the chosen encoding
  for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_hit
    assign hit[gi] = (5'(code) == encode_state(ENCODING, state_e'(3'(gi))));
  end

  // Select the tuple of the matching state, ERROR values when nothing matches
  always_comb begin
    v = OUT_ERROR;
    for (int k = 0; k < NUM_STATES; k++) begin
      if (hit[k]) begin
        v = state_outputs(state_e'(3'(k)));
      end
    end
  end

  assign n_o1 = v.n_o1;
  assign o    = v.o;
  assign err  = v.err;

endmodule

// File: rtl/fsm_encode_ctrl.sv
// Five-state Moore controller (IDLE, S1, S2, S3, ERROR) with selectable state
// encoding and output style, a minimum-dwell ERROR hold, recovery from
// illegal codes and a saturating count of entries into ERROR.
module fsm_encode_ctrl
  import fsm_encode_ctrl_pkg::*;
#(
  parameter int ENCODING = 0,   // 0 binary, 1 one-hot, 2 gray
  parameter int REG_OUT  = 1,   // 1 registered from next state, 0 decoded from state
  parameter int HOLD_W   = 4,
  parameter int ERR_HOLD = 3,   // 1 .. 2**HOLD_W-1
  parameter int CNT_W    = 8,
  localparam int SW      = (ENCODING == ENC_ONEHOT) ? 5 : 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       i,
  input  logic             cnt_clr,
  output logic             n_o1,
  output logic [2:0]       o,
  output logic             err,
  output logic             illegal,
  output logic [SW-1:0]    state_code,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [SW-1:0]     IDLE_CODE = SW'(encode_state(ENCODING, ST_IDLE));
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ERR_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [SW-1:0]     state_reg, state_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  dec_t              cur;
  state_e            nxt_st;
  logic              in_error;
  logic              entry;
  logic              i1, i2, i3, i4;

  assign i1 = i[0];
  assign i2 = i[1];
  assign i3 = i[2];
  assign i4 = i[3];

  // Classify the current code; illegal codes are steered to ERROR below
  always_comb begin
    cur      = decode_state(ENCODING, 5'(state_reg));
    in_error = cur.legal && (cur.st == ST_ERROR);
  end

  // Next-state selection (first matching condition wins) and hold counter
  always_comb begin
    nxt_st    = ST_ERROR;
    hold_next = hold_reg;
    entry     = 1'b0;
    if (cur.legal) begin
      case (cur.st)
        ST_IDLE: begin
          if (i1 && i2)              nxt_st = ST_S1;
          else if (i1 && !i2 && i3)  nxt_st = ST_S2;
          else if (!i1)              nxt_st = ST_IDLE;
          else                       nxt_st = ST_ERROR;
        end
        ST_S1: begin
          if (i1 && !i2 && i3)       nxt_st = ST_S3;
          else if (i2 && i3)         nxt_st = ST_S2;
          else if (!i2)              nxt_st = ST_S1;
          else                       nxt_st = ST_ERROR;
        end
        ST_S2: begin
          if (!i3 && i4)             nxt_st = ST_S3;
          else if (i3)               nxt_st = ST_S2;
          else                       nxt_st = ST_ERROR;
        end
        ST_S3: begin
          if (i1 && i2)              nxt_st = ST_ERROR;
          else if (!i1)              nxt_st = ST_IDLE;
          else                       nxt_st = ST_S3;
        end
        ST_ERROR: begin
          // Dwell until the hold saturates, then leave only once i1 drops
          if (hold_reg < HOLD_LAST) begin
            nxt_st    = ST_ERROR;
            hold_next = hold_reg + HOLD_W'(1);
          end else if (i1) begin
            nxt_st = ST_ERROR;
          end else begin
            nxt_st = ST_IDLE;
          end
        end
        default: nxt_st = ST_ERROR;
      endcase
    end
    // Fresh entry into ERROR (including from an illegal code) restarts the hold
    entry = (nxt_st == ST_ERROR) && !in_error;
    if (entry) begin
      hold_next = '0;
    end
  end

  // Entry counter: clear wins over increment, saturates at all-ones
  always_comb begin
    cnt_next = cnt_reg;
    if (cnt_clr) begin
      cnt_next = '0;
    end else if (entry && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  assign state_next = SW'(encode_state(ENCODING, nxt_st));

  // State, hold and counter registers; reset takes effect immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE_CODE;
      hold_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign illegal    = !cur.legal;
  assign state_code = state_reg;
  assign err_cnt    = cnt_reg;

  if (REG_OUT != 0) begin : g_reg_out
    logic       dn_o1;
    logic [2:0] d_o;
    logic       d_err;
    logic       n_o1_reg;
    logic [2:0] o_reg;
    logic       err_reg;

    fsm_out_decode #(
      .ENCODING (ENCODING),
      .SW       (SW)
    ) u_dec (
      .code (state_next),
      .n_o1 (dn_o1),
      .o    (d_o),
      .err  (d_err)
    );

    // Outputs of the upcoming state, captured on the same edge as the state
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        n_o1_reg <= OUT_IDLE.n_o1;
        o_reg    <= OUT_IDLE.o;
        err_reg  <= OUT_IDLE.err;
      end else begin
        n_o1_reg <= dn_o1;
        o_reg    <= d_o;
        err_reg  <= d_err;
      end
    end

    assign n_o1 = n_o1_reg;
    assign o    = o_reg;
    assign err  = err_reg;
  end else begin : g_comb_out
    fsm_out_decode #(
      .ENCODING (ENCODING),
      .SW       (SW)
    ) u_dec (
      .code (state_reg),
      .n_o1 (n_o1),
      .o    (o),
      .err  (err)
    );
  end

endmodule

// File: tb/tb_fsm_encode_ctrl.sv
// Bench for fsm_encode_ctrl: six instances (ENCODING 0/1/2 x REG_OUT 0/1)
// share one stimulus stream; a queue-based scoreboard carries the expected
// state and err_cnt of every clocked step to a monitor that checks all six.
module tb_fsm_encode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i;
  logic       cnt_clr;

  logic [4:0] code_a [6];
  logic       no1_a  [6];
  logic [2:0] o_a    [6];
  logic       err_a  [6];
  logic       ill_a  [6];
  logic [7:0] cnt_a  [6];

  int n_tests = 0;
  int n_fail  = 0;

  // Expected codes per encoding: IDLE,S1,S2,S3,ERROR
  localparam logic [4:0] CODES [3][5] = '{
    '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4},
    '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000},
    '{5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110}
  };
  // Expected {n_o1, o4, o3, o2, err} per state
  localparam logic [4:0] OUTS [5] = '{5'b1_000_0, 5'b0_001_0, 5'b1_011_0, 5'b1_100_0, 5'b1_000_1};
  // Illegal codes forced per instance
  localparam logic [4:0] BAD [6] = '{5'd7, 5'd7, 5'b00011, 5'b00011, 5'd7, 5'd7};

  // Directed vectors {i, expected state, expected err_cnt}
  localparam logic [15:0] TV [39] = '{
    16'h3100, 16'h5300, 16'h3401, 16'h0401, 16'h0401, 16'h0001,
    16'h1402, 16'h1402, 16'h1402, 16'h1402, 16'h1402, 16'h0002,
    16'h5202, 16'h4202, 16'h8302, 16'h0002, 16'h3102, 16'h0102,
    16'h6202, 16'h0403, 16'h0403, 16'h0403, 16'h0003, 16'h3103,
    16'h5303, 16'h1303, 16'h0003, 16'h3103, 16'h3404, 16'h0404,
    16'h0404, 16'h0004, 16'h5204, 16'hC204, 16'h8304, 16'h0004,
    16'hE004, 16'h1405, 16'h0405
  };

  typedef struct {
    int    st;
    int    cnt;
    string tag;
  } exp_t;

  exp_t sb [$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 6; gi++) begin : g_cfg
    localparam int ENC = gi / 2;
    localparam int RO  = gi % 2;
    localparam int SW  = (ENC == 1) ? 5 : 3;
    logic [SW-1:0] sc;
    logic          n_o1_w;
    logic [2:0]    o_w;
    logic          err_w;
    logic          ill_w;
    logic [7:0]    cnt_w;

    fsm_encode_ctrl #(
      .ENCODING (ENC),
      .REG_OUT  (RO),
      .HOLD_W   (4),
      .ERR_HOLD (3),
      .CNT_W    (8)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .i          (i),
      .cnt_clr    (cnt_clr),
      .n_o1       (n_o1_w),
      .o          (o_w),
      .err        (err_w),
      .illegal    (ill_w),
      .state_code (sc),
      .err_cnt    (cnt_w)
    );

    assign code_a[gi] = 5'(sc);
    assign no1_a[gi]  = n_o1_w;
    assign o_a[gi]    = o_w;
    assign err_a[gi]  = err_w;
    assign ill_a[gi]  = ill_w;
    assign cnt_a[gi]  = cnt_w;
  end

  task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d (enc=%0d reg_out=%0d): got %0h expected %0h", name, k, k / 2, k % 2, act, exp);
    end
  endtask

  task automatic check_all(input int st, input int cnt, input string tag);
    for (int k = 0; k < 6; k++) begin
      cmp({tag, ".code"}, k, 32'(code_a[k]), 32'(CODES[k / 2][st]));
      cmp({tag, ".outs"}, k, 32'({no1_a[k], o_a[k], err_a[k]}), 32'(OUTS[st]));
      cmp({tag, ".illegal"}, k, 32'(ill_a[k]), 32'd0);
      cmp({tag, ".err_cnt"}, k, 32'(cnt_a[k]), 32'(cnt));
    end
  endtask

  // Drive one clocked step and queue what must be seen after the edge
  task automatic step(input logic rv, input logic [3:0] iv, input logic clr, input int st, input int cnt, input string tag);
    exp_t e;
    @(negedge clk);
    rst     = rv;
    i       = iv;
    cnt_clr = clr;
    e.st  = st;
    e.cnt = cnt;
    e.tag = tag;
    sb.push_back(e);
    $display("[TB] step %s: rst=%0b i=%b clr=%0b -> state %0d err_cnt %0d", tag, rv, iv, clr, st, cnt);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 5) begin
      @(posedge clk);
      #2;
      w++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: one expectation per clock edge, checked shortly after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_all(e.st, e.cnt, e.tag);
      end
    end
  end

  initial begin
    rst     = 1'b0;
    i       = 4'h0;
    cnt_clr = 1'b0;

    step(1'b0, 4'h0, 1'b0, 0, 0, "reset0");
    step(1'b0, 4'h0, 1'b0, 0, 0, "reset1");

    for (int t = 0; t < 39; t++) begin
      step(1'b1, TV[t][15:12], 1'b0, int'(TV[t][11:8]), int'(TV[t][7:0]), $sformatf("tv%0d", t + 1));
    end

    // Reset in the middle of an ERROR hold
    drain();
    @(negedge clk);
    rst = 1'b0;
    i   = 4'h0;
    #1;
    check_all(0, 0, "rst_mid_hold");
    $display("[TB] async reset asserted mid-hold");
    step(1'b0, 4'h0, 1'b0, 0, 0, "rst_hold_low");
    step(1'b1, 4'h3, 1'b0, 1, 0, "post_rst_s1");
    step(1'b1, 4'h5, 1'b0, 3, 0, "post_rst_s3");
    step(1'b1, 4'h0, 1'b0, 0, 0, "post_rst_idle");

    // Drive err_cnt to saturation
    for (int n = 1; n <= 256; n++) begin
      int ec;
      ec = (n > 255) ? 255 : n;
      step(1'b1, 4'h1, 1'b0, 4, ec, $sformatf("sat_entry%0d", n));
      step(1'b1, 4'h0, 1'b0, 4, ec, "sat_hold1");
      step(1'b1, 4'h0, 1'b0, 4, ec, "sat_hold2");
      step(1'b1, 4'h0, 1'b0, 0, ec, "sat_exit");
    end
    step(1'b1, 4'h1, 1'b1, 4, 0, "clr_entry");
    step(1'b1, 4'h0, 1'b0, 4, 0, "clr_hold1");
    step(1'b1, 4'h0, 1'b0, 4, 0, "clr_hold2");
    step(1'b1, 4'h0, 1'b0, 0, 0, "clr_exit");

    // Illegal code recovery
    drain();
    @(negedge clk);
    i = 4'h0;
    force g_cfg[0].dut.state_reg = 3'b111;
    force g_cfg[1].dut.state_reg = 3'b111;
    force g_cfg[2].dut.state_reg = 5'b00011;
    force g_cfg[3].dut.state_reg = 5'b00011;
    force g_cfg[4].dut.state_reg = 3'b111;
    force g_cfg[5].dut.state_reg = 3'b111;
    #1;
    $display("[TB] illegal code forced");
    for (int k = 0; k < 6; k++) begin
      cmp("illegal_flag", k, 32'(ill_a[k]), 32'd1);
      cmp("illegal_code", k, 32'(code_a[k]), 32'(BAD[k]));
      if (k % 2 == 0) begin
        cmp("illegal_outs", k, 32'({no1_a[k], o_a[k], err_a[k]}), 32'(OUTS[4]));
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      cmp("illegal_next_err", k, 32'(err_a[k]), 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    release g_cfg[0].dut.state_reg;
    release g_cfg[1].dut.state_reg;
    release g_cfg[2].dut.state_reg;
    release g_cfg[3].dut.state_reg;
    release g_cfg[4].dut.state_reg;
    release g_cfg[5].dut.state_reg;
    step(1'b0, 4'h0, 1'b0, 0, 0, "rst_after_illegal");
    step(1'b1, 4'h3, 1'b0, 1, 0, "final_s1");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound on total run time
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: run still active at time %0t, expected completion", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
